// File: rtl/pio_out_blink.sv
// -----------------------------------------------------------------------------
// pio_out_blink
//
// Parametrised Avalon-MM slave output PIO with atomic bit set/clear and an
// optional prescaled hardware blink engine that toggles masked output bits
// without CPU involvement. Drives board pins such as LED columns, LED rows
// and enables.
//
// Optional feature macro: PIO_OUT_BLINK_EN
//   defined   : MASK / PERIOD / CTRL registers, blink counter and phase exist,
//               out_port = DATA ^ (MASK & {PHASE}).
//   undefined : no counter or phase logic; addresses 1..3 read 0 and ignore
//               writes; out_port = DATA.
//
// Register map (word addresses):
//   0 DATA     RW
//   1 MASK     RW  blink mask
//   2 PERIOD   RW  PERIOD_WIDTH bits
//   3 CTRL     bit0 EN (RW), bit1 PHASE (RO)
//   4 OUTSET   WO  DATA |= wd, reads 0
//   5 OUTCLEAR WO  DATA &= ~wd, reads 0
//   6 OUT      RO  current out_port
//   7 reserved, reads 0, writes ignored
//
// Ports:
//   clk        in   system clock, rising-edge
//   reset      in   asynchronous active-high reset
//   address    in   [2:0]  word register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [31:0] write data (truncated to register width)
//   readdata   out  [31:0] zero-wait-state read data, upper bits 0
//   out_port   out  [DATA_WIDTH-1:0] pin drive
// -----------------------------------------------------------------------------
module pio_out_blink #(
  parameter int          DATA_WIDTH   = 5,
  parameter int          PERIOD_WIDTH = 24,
  parameter logic [31:0] RESET_VALUE  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [DATA_WIDTH-1:0] DATA_INIT = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  wr_s;
  logic [DATA_WIDTH-1:0] wd_data_s;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] data_nxt_s;
  logic [31:0]           rd_s;
  logic                  unused_wd_s;

  assign wr_s      = chipselect & ~write_n;
  assign wd_data_s = writedata[DATA_WIDTH-1:0];

  // Upper write-data bits beyond the register widths are intentionally dropped.
  assign unused_wd_s = ^writedata;

`ifdef PIO_OUT_BLINK_EN
  logic [DATA_WIDTH-1:0]   mask_r;
  logic [PERIOD_WIDTH-1:0] period_r;
  logic [PERIOD_WIDTH-1:0] count_r;
  logic                    en_r;
  logic                    phase_r;
  logic                    mask_wr_s;
  logic                    period_wr_s;
  logic                    ctrl_wr_s;

  assign mask_wr_s   = wr_s & (address == 3'd1);
  assign period_wr_s = wr_s & (address == 3'd2);
  assign ctrl_wr_s   = wr_s & (address == 3'd3);

  // Blink configuration registers: MASK, PERIOD and the EN bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r   <= {DATA_WIDTH{1'b0}};
      period_r <= {PERIOD_WIDTH{1'b0}};
      en_r     <= 1'b0;
    end else begin
      if (mask_wr_s) begin
        mask_r <= wd_data_s;
      end
      if (period_wr_s) begin
        period_r <= writedata[PERIOD_WIDTH-1:0];
      end
      if (ctrl_wr_s) begin
        en_r <= writedata[0];
      end
    end
  end

  // Blink prescaler and phase. A disabling write, or an enabling write while
  // idle, restarts from count 0 / phase 0. Rewriting EN=1 while already
  // running falls through to normal counting. A PERIOD rewrite while running
  // restarts the count so a smaller period never wraps through 2^PERIOD_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {PERIOD_WIDTH{1'b0}};
      phase_r <= 1'b0;
    end else if (ctrl_wr_s && (!writedata[0] || !en_r)) begin
      count_r <= {PERIOD_WIDTH{1'b0}};
      phase_r <= 1'b0;
    end else if (en_r) begin
      if (period_wr_s) begin
        count_r <= {PERIOD_WIDTH{1'b0}};
      end else if (count_r == period_r) begin
        count_r <= {PERIOD_WIDTH{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        count_r <= count_r + PERIOD_WIDTH'(1'b1);
      end
    end else begin
      count_r <= {PERIOD_WIDTH{1'b0}};
      phase_r <= 1'b0;
    end
  end

  assign out_port = data_r ^ (mask_r & {DATA_WIDTH{phase_r}});
`else
  assign out_port = data_r;
`endif

  // Next DATA value: plain write, atomic set, or atomic clear.
  always_comb begin
    data_nxt_s = data_r;
    if (wr_s) begin
      case (address)
        3'd0:    data_nxt_s = wd_data_s;
        3'd4:    data_nxt_s = data_r | wd_data_s;
        3'd5:    data_nxt_s = data_r & ~wd_data_s;
        default: data_nxt_s = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // DATA register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= DATA_INIT;
    end else begin
      data_r <= data_nxt_s;
    end
  end

  // Zero-wait-state read mux; deliberately ignores chipselect.
  always_comb begin
    rd_s = 32'd0;
    case (address)
      3'd0: rd_s[DATA_WIDTH-1:0] = data_r;
`ifdef PIO_OUT_BLINK_EN
      3'd1: rd_s[DATA_WIDTH-1:0] = mask_r;
      3'd2: rd_s[PERIOD_WIDTH-1:0] = period_r;
      3'd3: rd_s[1:0] = {phase_r, en_r};
`endif
      3'd6: rd_s[DATA_WIDTH-1:0] = out_port;
      default: rd_s = 32'd0;
    endcase
  end

  assign readdata = rd_s;

endmodule
